// File: rtl/asu_seq.sv
// Sequential add/shift unit: one (mode, x, y) operation per valid/ready handshake.
// Add completes in one cycle; left shift iterates one bit per cycle.
module asu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             carry,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH:0] ACC_MASK = {1'b0, {WIDTH{1'b1}}};

    state_t         state;
    logic [WIDTH:0] acc;
    logic [2:0]     cnt;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] acc_shl;

    // Full-width sum keeps the carry; the shift drops anything past bit WIDTH-1.
    assign sum      = {1'b0, x} + {1'b0, y};
    assign acc_shl  = (acc << 1) & ACC_MASK;
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (mode) begin
                            {carry, out} <= sum;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end else if (y[2:0] == 3'd0) begin
                            out       <= x;
                            carry     <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            acc   <= {1'b0, x};
                            cnt   <= y[2:0];
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_shl;
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        out       <= acc_shl[WIDTH-1:0];
                        carry     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(carry)));

    a_shift_count_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SHIFT) |-> (cnt != 3'd0));

endmodule

// File: tb/tb_asu_seq.sv
// Scoreboard bench for asu_seq: expected {carry, out} queued at accept, checked on out_valid.
module tb_asu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [7:0] x;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       carry;
    logic [7:0] out;

    int errors = 0;
    int checks = 0;
    logic [8:0] sb[$];

    asu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .carry     (carry),
        .out       (out)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model(input bit m, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] sh;
        if (m) return {1'b0, a} + {1'b0, b};
        sh = a << b[2:0];
        return {1'b0, sh};
    endfunction

    function automatic int model_lat(input bit m, input logic [7:0] b);
        if (m || b[2:0] == 3'd0) return 1;
        return 1 + int'(b[2:0]);
    endfunction

    // Presents an operation until accepted; leaves time at #1 after the accept edge.
    task automatic issue(input bit m, input logic [7:0] a, input logic [7:0] b,
                         output bit ok, output int edges);
        bit rdy;
        ok = 1'b0;
        edges = 0;
        mode = m; x = a; y = b; in_valid = 1'b1;
        while (!ok && edges < 50) begin
            rdy = in_ready;
            @(posedge clk); #1;
            edges++;
            if (rdy) ok = 1'b1;
        end
        if (ok) sb.push_back(model(m, a, b));
        in_valid = 1'b0;
        x = ~a; y = ~b; mode = ~m;
    endtask

    // Counts edges from the accept edge until out_valid is seen; flags in_ready seen high meanwhile.
    task automatic wait_valid(output int lat, output bit ready_seen);
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; x = '0; y = '0; out_ready = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({carry, out} !== 9'h000) begin errors++; $display("FAIL reset_result got=%h exp=000", {carry, out}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add(input logic [7:0] a, input logic [7:0] b);
        bit ok, rs; int edges, lat; logic [8:0] exp;
        issue(1'b1, a, b, ok, edges);
        checks++; if (!ok || edges != 1) begin errors++; $display("FAIL add_accept ok=%b edges=%0d exp_edges=1", ok, edges); end
        wait_valid(lat, rs);
        checks++; if (lat != 1 || out_valid !== 1'b1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        exp = sb.size() ? sb.pop_front() : 9'h1xx;
        checks++; if ({carry, out} !== exp) begin errors++; $display("FAIL add_result got=%h exp=%h", {carry, out}, exp); end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_handshake out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
        checks++; if ({carry, out} !== exp) begin errors++; $display("FAIL add_hold_after got=%h exp=%h", {carry, out}, exp); end
    endtask

    task automatic test_shift(input logic [7:0] a, input logic [7:0] b, input int exp_lat);
        bit ok, rs; int edges, lat; logic [8:0] exp;
        issue(1'b0, a, b, ok, edges);
        checks++; if (!ok) begin errors++; $display("FAIL shift_accept got=0 exp=1"); end
        wait_valid(lat, rs);
        checks++; if (lat != exp_lat || out_valid !== 1'b1) begin errors++; $display("FAIL shift_latency got=%0d exp=%0d", lat, exp_lat); end
        checks++; if (rs) begin errors++; $display("FAIL shift_in_ready_busy got=1 exp=0"); end
        exp = sb.size() ? sb.pop_front() : 9'h1xx;
        checks++; if ({carry, out} !== exp) begin errors++; $display("FAIL shift_result got=%h exp=%h", {carry, out}, exp); end
        consume();
    endtask

    task automatic test_backpressure();
        bit ok, rs; int edges, lat; logic [8:0] exp;
        issue(1'b1, 8'h03, 8'h04, ok, edges);
        wait_valid(lat, rs);
        exp = sb.size() ? sb[0] : 9'h1xx;
        mode = 1'b1; x = 8'h01; y = 8'h01; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {carry, out} !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold valid=%b res=%h in_ready=%b exp=1/%h/0", out_valid, {carry, out}, in_ready, exp);
            end
        end
        exp = sb.size() ? sb.pop_front() : 9'h1xx;
        checks++; if ({carry, out} !== 9'h007) begin errors++; $display("FAIL bp_result got=%h exp=007", {carry, out}); end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        sb.push_back(model(1'b1, 8'h01, 8'h01));
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_new_accept valid=%b exp=1", out_valid); end
        exp = sb.size() ? sb.pop_front() : 9'h1xx;
        checks++; if ({carry, out} !== exp) begin errors++; $display("FAIL bp_new_result got=%h exp=%h", {carry, out}, exp); end
        consume();
    endtask

    task automatic test_reset_mid_shift();
        bit ok, rs; int edges, lat; logic [8:0] exp;
        checks++; if ({carry, out} !== 9'h002) begin errors++; $display("FAIL last_result_held got=%h exp=002", {carry, out}); end
        issue(1'b0, 8'h01, 8'h07, ok, edges);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++; if (out_valid !== 1'b0 || out !== 8'h00 || carry !== 1'b0) begin errors++; $display("FAIL rst_abort valid=%b out=%h carry=%b exp=0/00/0", out_valid, out, carry); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_abort_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        rs = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) rs = 1'b1;
        end
        checks++; if (rs) begin errors++; $display("FAIL rst_aborted_reported got=1 exp=0"); end
        issue(1'b1, 8'h10, 8'h20, ok, edges);
        wait_valid(lat, rs);
        checks++; if (lat != 1 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_add_latency got=%0d exp=1", lat); end
        exp = sb.size() ? sb.pop_front() : 9'h1xx;
        checks++; if ({carry, out} !== 9'h030 || exp !== 9'h030) begin errors++; $display("FAIL rst_add_result got=%h exp=030", {carry, out}); end
        consume();
    endtask

    task automatic test_back_to_back();
        bit ok, rs; int edges, lat, exp_lat; logic [8:0] exp;
        bit m; logic [7:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            m = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            exp_lat = model_lat(m, b);
            issue(m, a, b, ok, edges);
            wait_valid(lat, rs);
            checks++; if (!ok || lat != exp_lat) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
            exp = sb.size() ? sb.pop_front() : 9'h1xx;
            checks++; if ({carry, out} !== exp) begin errors++; $display("FAIL b2b_result[%0d] m=%b x=%h y=%h got=%h exp=%h", i, m, a, b, {carry, out}, exp); end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add(8'hFF, 8'h01);
        test_add(8'h7F, 8'h80);
        test_shift(8'h81, 8'h03, 4);
        test_shift(8'h5A, 8'hF8, 1);
        test_shift(8'hC3, 8'h07, 8);
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/asu_seq.md
# asu_seq

Sequential add/shift unit (ASU) with valid/ready handshakes, the design-side counterpart to the pattern-driven ASU bench. It accepts one `(mode, x, y)` operation per transaction and returns `{carry, out}` bit-exact to the combinational ASU golden model: mode 1 adds, mode 0 left-shifts. The shift is iterative, one bit per cycle, so the bench must wait on `out_valid` instead of sampling a fixed cycle.

## Interface
- `WIDTH`, default 8: operand and result width.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low. Clears all state immediately.
- `in_valid`, input, 1: operation presented on `mode`/`x`/`y`.
- `in_ready`, output, 1: unit can accept an operation. Combinational: high exactly when state is IDLE.
- `mode`, input, 1: selects the operation. 1 = add, 0 = shift left.
- `x`, input, WIDTH: first operand.
- `y`, input, WIDTH: second operand. In shift mode only `y[2:0]` is used, as the shift amount.
- `out_valid`, output, 1: result valid. Registered; high exactly in state DONE.
- `out_ready`, input, 1: consumer accepts the result.
- `carry`, output, 1: carry out of the add. Registered; always 0 for a shift.
- `out`, output, WIDTH: result. Registered.

## Operation
- State machine states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Internal registers:
  - `acc`, WIDTH+1 bits.
  - `cnt`, 3 bits.
  - Result registers for `out` and `carry`.
- Accept rule: an operation is accepted on a rising edge where `in_valid && in_ready`. Operands are captured only at that edge and may change afterwards.
- IDLE with an accepted add:
  - `{carry, out} <= {1'b0, x} + {1'b0, y}`, computed WIDTH+1 wide with no truncation before the carry.
  - Next state DONE.
- IDLE with an accepted shift and `y[2:0]` = 0:
  - `out <= x`, `carry <= 0`.
  - Next state DONE.
- IDLE with an accepted shift and `y[2:0]` ≠ 0:
  - `acc <= x`, `cnt <= y[2:0]`.
  - Next state SHIFT.
- SHIFT, on every edge:
  - `acc <= acc << 1`, with zero fill and bits above WIDTH-1 discarded.
  - `cnt <= cnt - 1`.
  - When `cnt` == 1: load `out` with the shifted value, set `carry <= 0`, next state DONE.
- DONE:
  - `out_valid` = 1.
  - `out`/`carry` are held stable until the edge where `out_ready` = 1.
  - That edge returns the unit to IDLE.
- `out`/`carry` keep their last result outside DONE. They change only on entry to DONE.
- `in_valid` is ignored outside IDLE. There is no queueing, and operations are not dropped silently: the source must hold `in_valid` until it sees `in_ready`.

## Timing
- Reset values:
  - State: IDLE.
  - `out` = 0, `carry` = 0, `out_valid` = 0.
  - `acc` = 0, `cnt` = 0.
  - `in_ready` = 1 while `rst_n` is low, since state is IDLE; nothing is accepted because state is held in reset.
- Add latency: `out_valid` rises after the accept edge, so 1 cycle.
- Shift latency: 1 cycle when amount n = 0, otherwise 1 + n cycles. Maximum is 8 cycles (n = 7).
- Throughput, measured accept to accept:
  - Minimum 2 cycles: accept, then DONE with `out_ready` = 1.
  - The unit never accepts in the same cycle that `out_valid` is high.
- Backpressure: `out_ready` low holds DONE indefinitely, and `in_ready` stays low throughout.
- Reset mid-operation (SHIFT or DONE):
  - Aborts immediately, with no clock edge needed.
  - Clears `out_valid` and zeroes `out`/`carry`.
  - The aborted operation is never reported.
- `rst_n` deassertion is synchronous-safe: the first accept can occur on the first rising edge after release.

## Test plan
- Add with carry: `mode`=1, `x`=8'hFF, `y`=8'h01. Required: `out_valid` one cycle after accept with `{carry, out}` = 9'h100.
- Add without carry: `mode`=1, `x`=8'h7F, `y`=8'h80. Required: `{carry, out}` = 9'h0FF with latency 1.
- Shift by 3: `mode`=0, `x`=8'h81, `y`=8'h03. Required: `out` = 8'h08, `carry` = 0, `out_valid` exactly 4 cycles after accept, `in_ready` low in between.
- Shift by 0, upper bits of `y` ignored: `mode`=0, `x`=8'h5A, `y`=8'hF8. Required: `out` = 8'h5A, `carry` = 0, latency 1.
- Backpressure:
  - Setup: hold `out_ready` = 0 for 5 cycles in DONE while driving a new `in_valid`.
  - Required while held: `out_valid`, `out` and `carry` stay stable; `in_ready` stays 0; the new operation is not accepted.
  - Required on release: the new operation is accepted once the unit is back in IDLE.
- Reset mid-shift:
  - Setup: pull `rst_n` low two cycles into a shift with `x`=8'h01, `y`=8'h07.
  - Required immediately: `out_valid` = 0, `out` = 0, `in_ready` = 1.
  - Required after release: a subsequent add of 8'h10 + 8'h20 yields 9'h030.
